// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM of the multicycle RV32I core: steps each instruction through
// fetch/decode/execute/memory/writeback and drives datapath selects and enables.
module multicycle_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_zero,
  input  logic       i_lt,
  input  logic       i_ltu,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic       o_adr_src,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic       o_reg_write,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_result_src,
  output logic       o_retire,
  output logic       o_fault,
  output logic [3:0] o_state
);

  typedef enum logic [4:0] {
    S_IDLE   = 5'd0,  S_FETCH  = 5'd1,  S_DECODE = 5'd2,  S_MEMADR = 5'd3,
    S_MEMRD  = 5'd4,  S_MEMWB  = 5'd5,  S_MEMWR  = 5'd6,  S_EXR    = 5'd7,
    S_EXI    = 5'd8,  S_ALUWB  = 5'd9,  S_BRANCH = 5'd10, S_JAL    = 5'd11,
    S_JALR   = 5'd12, S_JALR2  = 5'd13, S_LUI    = 5'd14, S_AUIPC  = 5'd15,
    S_FAULT  = 5'd16
  } state_t;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state, next_state;
  logic [CW-1:0] wait_cnt;
  logic          mem_phase, timed_out, taken;

  assign mem_phase = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  // Fires on the TIMEOUT-th consecutive unanswered request cycle; ready is low then, so no strobe can fire.
  assign timed_out = (TIMEOUT != 0) && mem_phase && !i_mem_ready && (wait_cnt == LAST_WAIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (mem_phase && !i_mem_ready) wait_cnt <= wait_cnt + CW'(1);
      else                           wait_cnt <= '0;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   next_state = S_FETCH;
      S_FETCH:  if (timed_out) next_state = S_FAULT; else if (i_mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (i_opcode)
          7'b0000011, 7'b0100011: next_state = S_MEMADR;
          7'b0110011:             next_state = S_EXR;
          7'b0010011:             next_state = S_EXI;
          7'b1100011:             next_state = S_BRANCH;
          7'b1101111:             next_state = S_JAL;
          7'b1100111:             next_state = S_JALR;
          7'b0110111:             next_state = S_LUI;
          7'b0010111:             next_state = S_AUIPC;
          default:                next_state = S_FAULT;
        endcase
      end
      S_MEMADR: next_state = i_opcode[5] ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (timed_out) next_state = S_FAULT; else if (i_mem_ready) next_state = S_MEMWB;
      S_MEMWR:  if (timed_out) next_state = S_FAULT; else if (i_mem_ready) next_state = S_FETCH;
      S_MEMWB, S_ALUWB, S_BRANCH:       next_state = S_FETCH;
      S_EXR, S_EXI, S_LUI, S_AUIPC, S_JAL, S_JALR2: next_state = S_ALUWB;
      S_JALR:   next_state = S_JALR2;
      S_FAULT:  next_state = S_FAULT;
      default:  next_state = S_FAULT;
    endcase
  end

  always_comb begin
    case (i_funct3)
      3'b000:  taken = i_zero;
      3'b001:  taken = !i_zero;
      3'b100:  taken = i_lt;
      3'b101:  taken = !i_lt;
      3'b110:  taken = i_ltu;
      3'b111:  taken = !i_ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_adr_src    = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_reg_write  = 1'b0;
    o_alu_src_a  = 2'b00;
    o_alu_src_b  = 2'b00;
    o_alu_op     = 2'b00;
    o_result_src = 2'b00;
    o_retire     = 1'b0;
    o_fault      = 1'b0;
    case (state)
      S_FETCH: begin
        o_mem_req    = 1'b1;
        o_alu_src_b  = 2'b10;
        o_result_src = 2'b10;
        o_ir_write   = i_mem_ready;
        o_pc_write   = i_mem_ready;
      end
      S_DECODE: begin o_alu_src_a = 2'b01; o_alu_src_b = 2'b01; end
      S_MEMADR: begin o_alu_src_a = 2'b10; o_alu_src_b = 2'b01; end
      S_MEMRD:  begin o_mem_req = 1'b1; o_adr_src = 1'b1; end
      S_MEMWB:  begin o_result_src = 2'b01; o_reg_write = 1'b1; o_retire = 1'b1; end
      S_MEMWR: begin
        o_mem_req = 1'b1;
        o_mem_we  = 1'b1;
        o_adr_src = 1'b1;
        o_retire  = i_mem_ready;
      end
      S_EXR:    begin o_alu_src_a = 2'b10; o_alu_op = 2'b10; end
      S_EXI:    begin o_alu_src_a = 2'b10; o_alu_src_b = 2'b01; o_alu_op = 2'b10; end
      S_LUI:    begin o_alu_src_a = 2'b11; o_alu_src_b = 2'b01; end
      S_AUIPC:  begin o_alu_src_a = 2'b01; o_alu_src_b = 2'b01; end
      S_ALUWB:  begin o_reg_write = 1'b1; o_retire = 1'b1; end
      S_BRANCH: begin
        o_alu_src_a = 2'b10;
        o_alu_op    = 2'b01;
        o_retire    = 1'b1;
        o_pc_write  = taken;
      end
      S_JAL, S_JALR2: begin o_pc_write = 1'b1; o_alu_src_a = 2'b01; o_alu_src_b = 2'b10; end
      S_JALR:   begin o_alu_src_a = 2'b10; o_alu_src_b = 2'b01; end
      S_FAULT:  o_fault = 1'b1;
      default:  ;
    endcase
  end

  // FAULT does not fit the 4-bit debug field and reads back as 0; o_fault tells it apart from IDLE.
  assign o_state = state[3:0];

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected output vectors are queued
// as stimulus is applied and compared against the DUT mid-cycle.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero, lt, ltu, mem_ready;
  logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, retire, fault;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [3:0] state;
  logic [19:0] act;

  int n_checks = 0;
  int n_fails  = 0;
  logic [19:0] sb[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_funct3(funct3),
    .i_zero(zero), .i_lt(lt), .i_ltu(ltu), .i_mem_ready(mem_ready),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_adr_src(adr_src), .o_ir_write(ir_write),
    .o_pc_write(pc_write), .o_reg_write(reg_write), .o_alu_src_a(alu_src_a),
    .o_alu_src_b(alu_src_b), .o_alu_op(alu_op), .o_result_src(result_src),
    .o_retire(retire), .o_fault(fault), .o_state(state)
  );

  assign act = {state, mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, alu_op, result_src, retire, fault};

  function automatic logic [19:0] ex(input logic [3:0] st, input logic mreq, mwe, adr, irw, pcw, rw,
                                     input logic [1:0] sa, sbv, op, rs, input logic ret, flt);
    return {st, mreq, mwe, adr, irw, pcw, rw, sa, sbv, op, rs, ret, flt};
  endfunction

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_SYS = 7'b1110011;

  localparam logic [19:0] E_IDLE    = 20'h0;
  localparam logic [19:0] E_FETCH_W = ex(4'd1,  1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b10,2'b00,2'b10, 1'b0,1'b0);
  localparam logic [19:0] E_FETCH_G = ex(4'd1,  1'b1,1'b0,1'b0,1'b1,1'b1,1'b0, 2'b00,2'b10,2'b00,2'b10, 1'b0,1'b0);
  localparam logic [19:0] E_DECODE  = ex(4'd2,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,2'b01,2'b00,2'b00, 1'b0,1'b0);
  localparam logic [19:0] E_MEMADR  = ex(4'd3,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,2'b01,2'b00,2'b00, 1'b0,1'b0);
  localparam logic [19:0] E_MEMRD   = ex(4'd4,  1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00,2'b00, 1'b0,1'b0);
  localparam logic [19:0] E_MEMWB   = ex(4'd5,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b00,2'b00,2'b01, 1'b1,1'b0);
  localparam logic [19:0] E_MEMWR_W = ex(4'd6,  1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00,2'b00, 1'b0,1'b0);
  localparam logic [19:0] E_MEMWR_G = ex(4'd6,  1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00,2'b00, 1'b1,1'b0);
  localparam logic [19:0] E_EXR     = ex(4'd7,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,2'b00,2'b10,2'b00, 1'b0,1'b0);
  localparam logic [19:0] E_EXI     = ex(4'd8,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,2'b01,2'b10,2'b00, 1'b0,1'b0);
  localparam logic [19:0] E_ALUWB   = ex(4'd9,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b00,2'b00,2'b00, 1'b1,1'b0);
  localparam logic [19:0] E_BR_NT   = ex(4'd10, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,2'b00,2'b01,2'b00, 1'b1,1'b0);
  localparam logic [19:0] E_BR_T    = ex(4'd10, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 2'b10,2'b00,2'b01,2'b00, 1'b1,1'b0);
  localparam logic [19:0] E_JAL     = ex(4'd11, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 2'b01,2'b10,2'b00,2'b00, 1'b0,1'b0);
  localparam logic [19:0] E_JALR    = ex(4'd12, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,2'b01,2'b00,2'b00, 1'b0,1'b0);
  localparam logic [19:0] E_JALR2   = ex(4'd13, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 2'b01,2'b10,2'b00,2'b00, 1'b0,1'b0);
  localparam logic [19:0] E_LUI     = ex(4'd14, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b11,2'b01,2'b00,2'b00, 1'b0,1'b0);
  localparam logic [19:0] E_AUIPC   = ex(4'd15, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,2'b01,2'b00,2'b00, 1'b0,1'b0);
  localparam logic [19:0] E_FAULT   = ex(4'd0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00,2'b00, 1'b0,1'b1);

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        rdy, z, l, lu;
    logic [19:0] exp;
  } step_t;

  function automatic step_t r(input logic [6:0] op, input logic [2:0] f3,
                              input logic rdy, z, l, lu, input logic [19:0] exp);
    step_t s;
    s.op = op; s.f3 = f3; s.rdy = rdy; s.z = z; s.l = l; s.lu = lu; s.exp = exp;
    return s;
  endfunction

  // One cycle: drive inputs just after the falling edge, queue the expectation, settle.
  task automatic drive_row(input step_t s);
    @(negedge clk);
    opcode = s.op; funct3 = s.f3; mem_ready = s.rdy; zero = s.z; lt = s.l; ltu = s.lu;
    sb.push_back(s.exp);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [19:0] e;
    @(negedge clk);
    rst_n = 1'b0; opcode = OP_R; funct3 = 3'b000; mem_ready = 1'b0; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    sb.push_back(E_IDLE);
    #2;
    e = sb.pop_front(); n_checks++;
    if (act !== e) begin n_fails++; $display("[TB] FAIL reset_asserted: got %05h expected %05h", act, e); end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(E_IDLE);
    #2;
    e = sb.pop_front(); n_checks++;
    if (act !== e) begin n_fails++; $display("[TB] FAIL reset_released_idle: got %05h expected %05h", act, e); end
    drive_row(r(OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, E_FETCH_W));
    e = sb.pop_front(); n_checks++;
    if (act !== e) begin n_fails++; $display("[TB] FAIL first_fetch: got %05h expected %05h", act, e); end
    #1;
    rst_n = 1'b0;
    sb.push_back(E_IDLE);
    #1;
    e = sb.pop_front(); n_checks++;
    if (act !== e) begin n_fails++; $display("[TB] FAIL reset_mid_request: got %05h expected %05h", act, e); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    step_t rows[$];
    logic [19:0] e;
    for (int k = 0; k < 2; k++) begin
      rows.push_back(r(OP_R, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, E_FETCH_G));
      rows.push_back(r(OP_R, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, E_DECODE));
      rows.push_back(r(OP_R, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, E_EXR));
      rows.push_back(r(OP_R, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, E_ALUWB));
    end
    foreach (rows[i]) begin
      drive_row(rows[i]);
      e = sb.pop_front(); n_checks++;
      if (act !== e) begin n_fails++; $display("[TB] FAIL rtype[%0d]: got %05h expected %05h", i, act, e); end
    end
  endtask

  task automatic test_load_store();
    step_t rows[$];
    logic [19:0] e;
    rows.push_back(r(OP_LOAD, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, E_FETCH_G));
    rows.push_back(r(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, E_DECODE));
    rows.push_back(r(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, E_MEMADR));
    for (int k = 0; k < 3; k++) rows.push_back(r(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, E_MEMRD));
    rows.push_back(r(OP_LOAD, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, E_MEMRD));
    rows.push_back(r(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, E_MEMWB));
    rows.push_back(r(OP_STORE, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, E_FETCH_G));
    rows.push_back(r(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, E_DECODE));
    rows.push_back(r(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, E_MEMADR));
    rows.push_back(r(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, E_MEMWR_W));
    rows.push_back(r(OP_STORE, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, E_MEMWR_G));
    rows.push_back(r(OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, E_FETCH_W));
    rows.push_back(r(OP_R, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, E_FETCH_G));
    rows.push_back(r(OP_R, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, E_DECODE));
    rows.push_back(r(OP_R, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, E_EXR));
    rows.push_back(r(OP_R, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, E_ALUWB));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      e = sb.pop_front(); n_checks++;
      if (act !== e) begin n_fails++; $display("[TB] FAIL load_store[%0d]: got %05h expected %05h", i, act, e); end
    end
  endtask

  task automatic test_branch();
    step_t rows[$];
    logic [19:0] e;
    // {funct3, zero, lt, ltu, taken}
    logic [6:0] cases[7] = '{7'b001_1_0_0_0, 7'b001_0_0_0_1, 7'b110_0_0_1_1, 7'b010_1_1_1_0,
                             7'b000_1_0_0_1, 7'b101_0_0_0_1, 7'b111_0_1_1_0};
    foreach (cases[k]) begin
      rows.push_back(r(OP_BR, cases[k][6:4], 1'b1, cases[k][3], cases[k][2], cases[k][1], E_FETCH_G));
      rows.push_back(r(OP_BR, cases[k][6:4], 1'b1, cases[k][3], cases[k][2], cases[k][1], E_DECODE));
      rows.push_back(r(OP_BR, cases[k][6:4], 1'b1, cases[k][3], cases[k][2], cases[k][1],
                       cases[k][0] ? E_BR_T : E_BR_NT));
    end
    foreach (rows[i]) begin
      drive_row(rows[i]);
      e = sb.pop_front(); n_checks++;
      if (act !== e) begin n_fails++; $display("[TB] FAIL branch[%0d]: got %05h expected %05h", i, act, e); end
    end
  endtask

  task automatic test_jumps();
    step_t rows[$];
    logic [19:0] e;
    rows.push_back(r(OP_JAL, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, E_FETCH_G));
    rows.push_back(r(OP_JAL, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, E_DECODE));
    rows.push_back(r(OP_JAL, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, E_JAL));
    rows.push_back(r(OP_JAL, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, E_ALUWB));
    rows.push_back(r(OP_JALR, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, E_FETCH_G));
    rows.push_back(r(OP_JALR, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, E_DECODE));
    rows.push_back(r(OP_JALR, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, E_JALR));
    rows.push_back(r(OP_JALR, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, E_JALR2));
    rows.push_back(r(OP_JALR, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, E_ALUWB));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      e = sb.pop_front(); n_checks++;
      if (act !== e) begin n_fails++; $display("[TB] FAIL jumps[%0d]: got %05h expected %05h", i, act, e); end
    end
  endtask

  task automatic test_back_to_back();
    step_t rows[$];
    logic [19:0] e;
    logic [6:0]  ops[3] = '{OP_I, OP_LUI, OP_AUIPC};
    logic [19:0] exs[3] = '{E_EXI, E_LUI, E_AUIPC};
    foreach (ops[k]) begin
      rows.push_back(r(ops[k], 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, E_FETCH_G));
      rows.push_back(r(ops[k], 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, E_DECODE));
      rows.push_back(r(ops[k], 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, exs[k]));
      rows.push_back(r(ops[k], 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, E_ALUWB));
    end
    foreach (rows[i]) begin
      drive_row(rows[i]);
      e = sb.pop_front(); n_checks++;
      if (act !== e) begin n_fails++; $display("[TB] FAIL back_to_back[%0d]: got %05h expected %05h", i, act, e); end
    end
  endtask

  task automatic test_timeout();
    step_t rows[$];
    logic [19:0] e;
    do_reset();
    for (int k = 0; k < 4; k++) rows.push_back(r(OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, E_FETCH_W));
    for (int k = 0; k < 2; k++) rows.push_back(r(OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, E_FAULT));
    for (int k = 0; k < 3; k++) rows.push_back(r(OP_R, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, E_FAULT));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      e = sb.pop_front(); n_checks++;
      if (act !== e) begin n_fails++; $display("[TB] FAIL timeout[%0d]: got %05h expected %05h", i, act, e); end
    end
    @(negedge clk);
    rst_n = 1'b0;
    sb.push_back(E_IDLE);
    #2;
    e = sb.pop_front(); n_checks++;
    if (act !== e) begin n_fails++; $display("[TB] FAIL timeout_cleared_by_reset: got %05h expected %05h", act, e); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_illegal();
    step_t rows[$];
    logic [19:0] e;
    do_reset();
    rows.push_back(r(OP_SYS, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, E_FETCH_G));
    rows.push_back(r(OP_SYS, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, E_DECODE));
    rows.push_back(r(OP_R, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, E_FAULT));
    rows.push_back(r(OP_R, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, E_FAULT));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      e = sb.pop_front(); n_checks++;
      if (act !== e) begin n_fails++; $display("[TB] FAIL illegal[%0d]: got %05h expected %05h", i, act, e); end
    end
    @(negedge clk);
    rst_n = 1'b0;
    sb.push_back(E_IDLE);
    #2;
    e = sb.pop_front(); n_checks++;
    if (act !== e) begin n_fails++; $display("[TB] FAIL illegal_cleared_by_reset: got %05h expected %05h", act, e); end
    @(negedge clk);
    rst_n = 1'b1;
    drive_row(r(OP_R, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, E_FETCH_G));
    e = sb.pop_front(); n_checks++;
    if (act !== e) begin n_fails++; $display("[TB] FAIL refetch_after_fault: got %05h expected %05h", act, e); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; opcode = '0; funct3 = '0; zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_load_store();
    test_branch();
    test_jumps();
    test_back_to_back();
    test_timeout();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
